// File: rtl/rv32i_uc_multiciclo_if.sv
// Control bus between the multi-cycle RV32I control unit and its datapath.
// The master side is the control unit: it reads the instruction fields,
// the zero flag and the memory handshake, and drives every strobe and select.
interface rv32i_uc_multiciclo_if #(
   parameter int ALU_CTRL_W = 3,
   parameter int CNT_W      = 32
);
   logic                  zero;
   logic [6:0]            op;
   logic [2:0]            f3;
   logic                  f7;
   logic                  mem_ready;
   logic                  pcWrite;
   logic                  adrSrc;
   logic                  memWrite;
   logic                  irWrite;
   logic [1:0]            resSrc;
   logic [1:0]            aluSrcA;
   logic [1:0]            aluSrcB;
   logic [1:0]            immSrc;
   logic [ALU_CTRL_W-1:0] aluControl;
   logic                  regWrite;
   logic [CNT_W-1:0]      instret;
   logic                  illegal;

   modport master (
      input  zero, op, f3, f7, mem_ready,
      output pcWrite, adrSrc, memWrite, irWrite, resSrc, aluSrcA, aluSrcB,
             immSrc, aluControl, regWrite, instret, illegal
   );

   modport slave (
      output zero, op, f3, f7, mem_ready,
      input  pcWrite, adrSrc, memWrite, irWrite, resSrc, aluSrcA, aluSrcB,
             immSrc, aluControl, regWrite, instret, illegal
   );
endinterface

// File: rtl/rv32i_uc_multiciclo.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback for a shared-memory / single-ALU datapath.
// Supports memory wait states, an illegal-opcode trap and an instret counter.
// Optional feature macro UC_BNE_EN: when defined, bne (f3 = 001) is executed
// in the branch state with an inverted zero test; when undefined it traps.
module rv32i_uc_multiciclo #(
   parameter int ALU_CTRL_W = 3,
   parameter int MEM_HS     = 1,
   parameter int CNT_W      = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   rv32i_uc_multiciclo_if.master bus
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECR, EXECI, JAL, BEQ, ALUWB, TRAP
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD, OP_SUB, OP_FUNCT
   } aluop_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instret_q;
   logic             illegal_q;

   aluop_t           aluOp;
   logic [2:0]       aluCode;
   logic             rdy;
   logic             retire;
   logic             branchTaken;
   logic             isBranch;
   logic             pcWriteRaw, memWriteRaw, irWriteRaw, regWriteRaw;

   // Without handshaking every memory access completes in one cycle.
   assign rdy = (MEM_HS != 0) ? bus.mem_ready : 1'b1;

`ifdef UC_BNE_EN
   assign isBranch    = (bus.f3 == 3'b000) || (bus.f3 == 3'b001);
   assign branchTaken = bus.zero ^ bus.f3[0];
`else
   assign isBranch    = (bus.f3 == 3'b000);
   assign branchTaken = bus.zero;
`endif

   // Next-state and per-state Moore outputs; strobes are gated by reset below.
   always_comb begin
      state_d     = state_q;
      pcWriteRaw  = 1'b0;
      memWriteRaw = 1'b0;
      irWriteRaw  = 1'b0;
      regWriteRaw = 1'b0;
      bus.adrSrc  = 1'b0;
      bus.resSrc  = 2'b00;
      bus.aluSrcA = 2'b00;
      bus.aluSrcB = 2'b00;
      aluOp       = OP_ADD;
      retire      = 1'b0;
      case (state_q)
         FETCH: begin
            irWriteRaw  = rdy;
            pcWriteRaw  = rdy;
            bus.aluSrcB = 2'b10;
            bus.resSrc  = 2'b10;
            if (rdy) state_d = DECODE;
         end
         DECODE: begin
            bus.aluSrcA = 2'b01;
            bus.aluSrcB = 2'b01;
            case (bus.op)
               7'b0000011, 7'b0100011: state_d = MEMADR;
               7'b0110011:             state_d = EXECR;
               7'b0010011:             state_d = EXECI;
               7'b1101111:             state_d = JAL;
               7'b1100011:             state_d = isBranch ? BEQ : TRAP;
               default:                state_d = TRAP;
            endcase
         end
         MEMADR: begin
            bus.aluSrcA = 2'b10;
            bus.aluSrcB = 2'b01;
            state_d     = bus.op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            bus.adrSrc = 1'b1;
            if (rdy) state_d = MEMWB;
         end
         MEMWB: begin
            bus.resSrc  = 2'b01;
            regWriteRaw = 1'b1;
            retire      = 1'b1;
            state_d     = FETCH;
         end
         MEMWRITE: begin
            bus.adrSrc  = 1'b1;
            memWriteRaw = 1'b1;
            if (rdy) begin
               retire  = 1'b1;
               state_d = FETCH;
            end
         end
         EXECR: begin
            bus.aluSrcA = 2'b10;
            aluOp       = OP_FUNCT;
            state_d     = ALUWB;
         end
         EXECI: begin
            bus.aluSrcA = 2'b10;
            bus.aluSrcB = 2'b01;
            aluOp       = OP_FUNCT;
            state_d     = ALUWB;
         end
         JAL: begin
            bus.aluSrcA = 2'b01;
            bus.aluSrcB = 2'b10;
            pcWriteRaw  = 1'b1;
            state_d     = ALUWB;
         end
         ALUWB: begin
            regWriteRaw = 1'b1;
            retire      = 1'b1;
            state_d     = FETCH;
         end
         BEQ: begin
            bus.aluSrcA = 2'b10;
            aluOp       = OP_SUB;
            pcWriteRaw  = branchTaken;
            retire      = 1'b1;
            state_d     = FETCH;
         end
         TRAP: begin
            state_d = TRAP;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // ALU operation code; funct decoding only matters in the execute states.
   always_comb begin
      aluCode = 3'b000;
      case (aluOp)
         OP_ADD: aluCode = 3'b000;
         OP_SUB: aluCode = 3'b001;
         OP_FUNCT: begin
            case (bus.f3)
               3'b000:  aluCode = (bus.op[5] & bus.f7) ? 3'b001 : 3'b000;
               3'b010:  aluCode = 3'b101;
               3'b110:  aluCode = 3'b011;
               3'b111:  aluCode = 3'b010;
               default: aluCode = 3'b000;
            endcase
         end
         default: aluCode = 3'b000;
      endcase
   end

   // Immediate format depends only on the opcode.
   always_comb begin
      case (bus.op)
         7'b0100011: bus.immSrc = 2'b01;
         7'b1100011: bus.immSrc = 2'b10;
         7'b1101111: bus.immSrc = 2'b11;
         default:    bus.immSrc = 2'b00;
      endcase
   end

   // Strobes are held low while reset is asserted so nothing commits.
   assign bus.pcWrite    = pcWriteRaw  & reset_n;
   assign bus.memWrite   = memWriteRaw & reset_n;
   assign bus.irWrite    = irWriteRaw  & reset_n;
   assign bus.regWrite   = regWriteRaw & reset_n;
   assign bus.aluControl = ALU_CTRL_W'(aluCode);
   assign bus.instret    = instret_q;
   assign bus.illegal    = illegal_q;

   // State register, retired-instruction counter and sticky trap flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= FETCH;
         instret_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (retire) instret_q <= instret_q + CNT_W'(1);
         if (state_d == TRAP) illegal_q <= 1'b1;
      end
   end

endmodule

// File: doc/rv32i_uc_multiciclo.md
Name: rv32i_uc_multiciclo

Overview:
Multi-cycle RV32I control unit: a Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles. It drives the shared-memory/single-ALU datapath of the next processor generation. Generalises the single-cycle combinational control unit with memory wait-state handshaking, a parametrised ALU control width, an illegal-opcode trap and a retired-instruction counter.

Parameters:
ALU_CTRL_W, 3, aluControl width; codes are zero-extended into it; must be >=3.
MEM_HS, 1, 1 = honour mem_ready wait states; 0 = mem_ready ignored and treated as 1.
CNT_W, 32, instret width.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
zero  in  1  ALU zero flag.
op  in  7  instr[6:0].
f3  in  3  instr[14:12].
f7  in  1  instr[30].
mem_ready  in  1  memory access complete this cycle.
pcWrite  out  1  PC register enable.
adrSrc  out  1  memory address select: 0 = PC, 1 = ALU result.
memWrite  out  1  memory write strobe.
irWrite  out  1  IR/oldPC enable.
resSrc  out  2  result mux select: 00 = ALUOut, 01 = data, 10 = ALU result.
aluSrcA  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
aluSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = 4.
immSrc  out  2  immediate format: I = 00, S = 01, B = 10, J = 11.
aluControl  out  ALU_CTRL_W  ALU operation.
regWrite  out  1  register file write enable.
instret  out  CNT_W  retired-instruction count.
illegal  out  1  sticky trap flag.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, JAL, BEQ, ALUWB, TRAP.
- Reset (reset_n = 0, async): state = FETCH, instret = 0, illegal = 0.
- While reset_n = 0: pcWrite, irWrite, memWrite and regWrite are forced to 0. Other outputs show the FETCH values.
- Outputs decode combinationally from the current state; aluControl additionally from op/f3/f7; immSrc from op only.
- Transitions and per-state outputs (unlisted strobes = 0, unlisted selects = 00):
  - FETCH: irWrite = pcWrite = rdy; aluSrcB = 10; resSrc = 10; aluOp add. Next: DECODE when rdy, else stay in FETCH.
  - DECODE: aluSrcA = 01; aluSrcB = 01; aluOp add. Next by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 with f3 = 000 -> BEQ
    - anything else -> TRAP
  - MEMADR: aluSrcA = 10; aluSrcB = 01; aluOp add. Next: op[5] ? MEMWRITE : MEMREAD.
  - MEMREAD: adrSrc = 1. Next: MEMWB when rdy, else stay.
  - MEMWB: resSrc = 01; regWrite = 1. Next: FETCH.
  - MEMWRITE: adrSrc = 1; memWrite = 1, held every cycle until rdy. Next: FETCH when rdy.
  - EXECR: aluSrcA = 10; aluOp funct. Next: ALUWB.
  - EXECI: aluSrcA = 10; aluSrcB = 01; aluOp funct. Next: ALUWB.
  - JAL: aluSrcA = 01; aluSrcB = 10; pcWrite = 1; aluOp add. Next: ALUWB.
  - ALUWB: regWrite = 1. Next: FETCH.
  - BEQ: aluSrcA = 10; aluOp sub; pcWrite = zero. Next: FETCH.
  - TRAP: all strobes 0; illegal = 1. Held until reset.
- rdy = mem_ready when MEM_HS = 1, else 1.
- aluControl codes: add = 000, sub = 001, and = 010, or = 011, slt = 101.
- aluOp funct decode by f3:
  - 000 -> sub when op[5] & f7, else add
  - 010 -> slt
  - 110 -> or
  - 111 -> and
  - other -> add (no trap)
- instret increments by 1 (mod 2^CNT_W) on each transition into FETCH from MEMWB, MEMWRITE (rdy), ALUWB or BEQ. A JAL is counted once, at ALUWB.
- Reset asserted mid-instruction aborts it: no strobes issue and no instret update occurs.

Optional Feature:
Macro UC_BNE_EN.
- Defined: DECODE also sends op = 1100011, f3 = 001 to BEQ. In BEQ, pcWrite = zero ^ f3[0].
- Undefined: f3 = 001 branches go to TRAP; in BEQ, pcWrite = zero.

Test Plan:
1. add x, f7 = 0, MEM_HS = 1, mem_ready held 1 -> FETCH, DECODE, EXECR (aluControl = 000), ALUWB (regWrite = 1); 4 cycles total; instret goes 0 -> 1.
2. sub (f7 = 1) then or (f3 = 110) -> aluControl = 001 in EXECR, then 011.
3. lw with mem_ready low for 3 cycles in MEMREAD -> stays in MEMREAD 4 cycles; regWrite = 1 only in MEMWB; retires in 8 cycles.
4. beq with zero = 1 -> pcWrite = 1 in BEQ; with zero = 0 -> pcWrite = 0; instret +1 in both cases.
5. op = 0000000 -> TRAP, illegal = 1, all strobes stay 0 for 20 cycles; reset_n pulse -> illegal = 0, state FETCH, instret = 0.
6. bne (f3 = 001), zero = 0 -> with UC_BNE_EN: pcWrite = 1 in BEQ; without: illegal = 1.
